// File: rtl/neural_fetch_pc.sv
// PC / fetch unit: owns the program counter, issues valid/ack fetches, hands words to decode.
// Latency: IF_ACK in cycle N gives ID_VLD in cycle N+1. A stalled word parks in a one-entry skid.
// Backpressure: HALT with ID_VLD holds ID_*; a word acked during the stall is skidded and fetch pauses.
module neural_fetch_pc #(
  parameter int                  XLEN       = 32,
  parameter logic [XLEN-1:0]     RESET_PC   = 'h00000000,
  parameter logic [XLEN-1:0]     TRAP_PC    = 'h00000100,
  parameter int                  STEP       = 4,
  parameter int                  ALIGN_BITS = 2
) (
  input  logic            CLK,
  input  logic            RES_N,
  output logic            IF_REQ,
  output logic [XLEN-1:0] IF_ADDR,
  input  logic            IF_ACK,
  input  logic [31:0]     IF_DATA,
  output logic            ID_VLD,
  output logic [XLEN-1:0] ID_PC,
  output logic [31:0]     ID_INSN,
  input  logic            HALT,
  input  logic            REDIR_VLD,
  input  logic [XLEN-1:0] REDIR_PC,
  input  logic            TRAP_VLD,
  output logic            MISALIGN
);

  localparam logic [1:0]      S_BOOT  = 2'd0;
  localparam logic [1:0]      S_REQ   = 2'd1;
  localparam logic [1:0]      S_WAIT  = 2'd2;
  localparam logic [XLEN-1:0] LP_STEP = XLEN'(STEP);

  // architectural / pipeline state
  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_id_vld;
  logic [XLEN-1:0] r_id_pc;
  logic [31:0]     r_id_insn;
  logic            r_skid_vld;
  logic [XLEN-1:0] r_skid_pc;
  logic [31:0]     r_skid_insn;
  logic            r_kill;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_misalign;

  // decoded control
  logic            w_if_req;
  logic            w_redir;
  logic            w_mis;
  logic [XLEN-1:0] w_tgt;
  logic            w_ack;
  logic            w_free;
  logic            w_take;
  logic            w_to_id;
  logic            w_to_skid;
  logic            w_skid_out;
  logic            w_kill_ack;
  logic            w_redir_now;
  logic            w_redir_pend;
  logic [XLEN-1:0] w_pc_inc;

  assign w_if_req = (r_state == S_REQ);
  assign w_pc_inc = r_pc + LP_STEP;

  // redirect target selection: trap beats branch, a misaligned branch becomes a trap
  always_comb begin
    w_redir = TRAP_VLD | REDIR_VLD;
    w_mis   = REDIR_VLD & ~TRAP_VLD & (REDIR_PC[ALIGN_BITS-1:0] != '0);
    w_tgt   = (TRAP_VLD | w_mis) ? TRAP_PC : REDIR_PC;
  end

  // handshake qualification and data-path steering
  always_comb begin
    // an ack only counts while a request is actually outstanding
    w_ack        = w_if_req & IF_ACK;
    w_free       = ~r_id_vld | ~HALT;
    // a word is kept only if it is neither killed by an earlier redirect nor by one this cycle
    w_take       = w_ack & ~r_kill & ~w_redir;
    w_to_id      = w_take & w_free;
    w_to_skid    = w_take & ~w_free;
    w_skid_out   = (r_state == S_WAIT) & ~HALT & ~w_redir;
    w_kill_ack   = w_ack & r_kill & ~w_redir;
    // redirect can be applied now unless a request is in flight without its ack
    w_redir_now  = w_redir & (~w_if_req | IF_ACK);
    w_redir_pend = w_redir & w_if_req & ~IF_ACK;
  end

  // FSM: BOOT -> REQ, REQ <-> WAIT around decode stalls, redirects always land in REQ
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_state <= S_BOOT;
    end else begin
      case (r_state)
        S_BOOT:  r_state <= S_REQ;
        S_REQ:   if (w_to_skid) r_state <= S_WAIT;
        S_WAIT:  if (w_redir || w_skid_out) r_state <= S_REQ;
        default: r_state <= S_BOOT;
      endcase
      if (r_state == S_BOOT && w_redir) r_state <= S_REQ;
    end
  end

  // program counter: stays put while a request waits for its ack
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_pc <= RESET_PC;
    end else if (w_redir_now) begin
      r_pc <= w_tgt;
    end else if (w_kill_ack) begin
      r_pc <= r_pend_pc;
    end else if (w_take) begin
      r_pc <= w_pc_inc;
    end
  end

  // kill flag and pending target for redirects that arrive mid-request
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_kill    <= 1'b0;
      r_pend_pc <= '0;
    end else if (w_redir_pend) begin
      // a newer redirect simply overwrites the pending target
      r_kill    <= 1'b1;
      r_pend_pc <= w_tgt;
    end else if (w_redir_now || w_kill_ack) begin
      r_kill    <= 1'b0;
    end
  end

  // decode-facing register: load fresh word or skid word, drop when consumed, flush on redirect
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_id_vld  <= 1'b0;
      r_id_pc   <= '0;
      r_id_insn <= '0;
    end else if (w_redir) begin
      r_id_vld  <= 1'b0;
    end else if (w_to_id) begin
      r_id_vld  <= 1'b1;
      r_id_pc   <= r_pc;
      r_id_insn <= IF_DATA;
    end else if (w_skid_out) begin
      r_id_vld  <= 1'b1;
      r_id_pc   <= r_skid_pc;
      r_id_insn <= r_skid_insn;
    end else if (r_id_vld && !HALT) begin
      r_id_vld  <= 1'b0;
    end
  end

  // one-entry skid: catches the word acked while decode is stalled
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_skid_vld  <= 1'b0;
      r_skid_pc   <= '0;
      r_skid_insn <= '0;
    end else if (w_redir) begin
      r_skid_vld  <= 1'b0;
    end else if (w_to_skid) begin
      r_skid_vld  <= 1'b1;
      r_skid_pc   <= r_pc;
      r_skid_insn <= IF_DATA;
    end else if (w_skid_out) begin
      r_skid_vld  <= 1'b0;
    end
  end

  // misalign report, one cycle after the offending redirect
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_mis;
    end
  end

  assign IF_REQ   = w_if_req;
  assign IF_ADDR  = r_pc;
  assign ID_VLD   = r_id_vld;
  assign ID_PC    = r_id_pc;
  assign ID_INSN  = r_id_insn;
  assign MISALIGN = r_misalign;

endmodule

// File: tb/tb_neural_fetch_pc.sv
// Directed bench for neural_fetch_pc: boot, skid stall, redirects, misalign, trap priority, wrap, reset.
// Inputs change 1 ns after each rising edge; registered outputs are checked at the same point.
// Instruction data is a fixed function of the fetch address so expected words follow from expected PCs.
module tb_neural_fetch_pc;

  logic        clk;
  logic        res_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic        id_vld;
  logic [31:0] id_pc;
  logic [31:0] id_insn;
  logic        halt;
  logic        redir_vld;
  logic [31:0] redir_pc;
  logic        trap_vld;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] DKEY = 32'hC0DE_0000;

  neural_fetch_pc dut (
    .CLK(clk), .RES_N(res_n),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IF_DATA(if_data),
    .ID_VLD(id_vld), .ID_PC(id_pc), .ID_INSN(id_insn), .HALT(halt),
    .REDIR_VLD(redir_vld), .REDIR_PC(redir_pc), .TRAP_VLD(trap_vld),
    .MISALIGN(misalign)
  );

  assign if_data = DKEY ^ if_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"}, {31'd0, id_vld}, 32'd1);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_insn"}, id_insn, DKEY ^ pc);
  endtask

  initial begin
    res_n = 1'b0; if_ack = 1'b0; halt = 1'b0;
    redir_vld = 1'b0; redir_pc = '0; trap_vld = 1'b0;
    tick(); tick();
    chk("rst_if_req", {31'd0, if_req}, 32'd0);
    chk("rst_id_vld", {31'd0, id_vld}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_insn", id_insn, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);

    // 1: boot and sequential fetch with ack tied high
    res_n = 1'b1; if_ack = 1'b1;
    tick();
    chk("boot_if_req", {31'd0, if_req}, 32'd1);
    chk("boot_if_addr", if_addr, 32'h0);
    chk("boot_id_vld", {31'd0, id_vld}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("seq_if_addr", if_addr, 32'(4 * (k + 1)));
      chk_id("seq", 32'(4 * k));
    end

    // 2: stall three cycles, word 0x10 goes to skid
    halt = 1'b1;
    tick();
    chk("stall_if_req", {31'd0, if_req}, 32'd0);
    chk("stall_if_addr", if_addr, 32'h14);
    chk_id("stall0", 32'hC);
    tick();
    chk("stall1_if_req", {31'd0, if_req}, 32'd0);
    chk_id("stall1", 32'hC);
    tick();
    chk_id("stall2", 32'hC);
    halt = 1'b0;
    tick();
    chk("unstall_if_req", {31'd0, if_req}, 32'd1);
    chk_id("skid_out", 32'h10);
    tick();
    chk_id("after_skid", 32'h14);
    chk("after_skid_addr", if_addr, 32'h18);

    // 3: redirect to 0x40 while the request at 0x18 waits two cycles for its ack
    if_ack = 1'b0; redir_vld = 1'b1; redir_pc = 32'h40;
    tick();
    redir_vld = 1'b0;
    chk("kill_if_req", {31'd0, if_req}, 32'd1);
    chk("kill_if_addr", if_addr, 32'h18);
    chk("kill_flush", {31'd0, id_vld}, 32'd0);
    tick();
    chk("hold_if_addr", if_addr, 32'h18);
    if_ack = 1'b1;
    tick();
    chk("redir_if_addr", if_addr, 32'h40);
    chk("killed_word", {31'd0, id_vld}, 32'd0);
    tick();
    chk_id("redir_word", 32'h40);
    chk("redir_next", if_addr, 32'h44);

    // 4: misaligned redirect target becomes a trap
    redir_vld = 1'b1; redir_pc = 32'h42;
    tick();
    redir_vld = 1'b0; if_ack = 1'b0;
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_flush", {31'd0, id_vld}, 32'd0);
    chk("mis_if_addr", if_addr, 32'h100);
    tick();
    chk("mis_clear", {31'd0, misalign}, 32'd0);
    chk("mis_if_addr2", if_addr, 32'h100);

    // 5a: trap and branch together, trap wins
    trap_vld = 1'b1; redir_vld = 1'b1; redir_pc = 32'h80; if_ack = 1'b1;
    tick();
    trap_vld = 1'b0;
    chk("trap_wins", if_addr, 32'h100);
    chk("trap_flush", {31'd0, id_vld}, 32'd0);
    chk("trap_no_mis", {31'd0, misalign}, 32'd0);
    // 5b: two redirects while a request stalls, last target wins
    if_ack = 1'b0; redir_vld = 1'b1; redir_pc = 32'h200;
    tick();
    redir_pc = 32'h300;
    tick();
    redir_vld = 1'b0;
    chk("pend_hold", if_addr, 32'h100);
    if_ack = 1'b1;
    tick();
    chk("last_wins", if_addr, 32'h300);
    chk("last_killed", {31'd0, id_vld}, 32'd0);
    tick();
    chk_id("last_word", 32'h300);
    // 5c: wrap from 0xFFFFFFFC
    redir_vld = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_vld = 1'b0;
    chk("wrap_top", if_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero", if_addr, 32'h0);
    chk_id("wrap_word", 32'hFFFF_FFFC);
    tick();
    chk("wrap_four", if_addr, 32'h4);
    chk_id("wrap_word0", 32'h0);

    // 6: reset in the middle of an outstanding request
    if_ack = 1'b0; res_n = 1'b0;
    #1;
    chk("mrst_if_req", {31'd0, if_req}, 32'd0);
    chk("mrst_id_vld", {31'd0, id_vld}, 32'd0);
    chk("mrst_id_insn", id_insn, 32'd0);
    chk("mrst_id_pc", id_pc, 32'd0);
    chk("mrst_if_addr", if_addr, 32'd0);
    tick();
    res_n = 1'b1;
    #1;
    chk("mrst_boot", {31'd0, if_req}, 32'd0);
    tick();
    chk("mrst_req", {31'd0, if_req}, 32'd1);
    chk("mrst_addr", if_addr, 32'h0);
    chk("mrst_novld", {31'd0, id_vld}, 32'd0);
    if_ack = 1'b1;
    tick();
    chk_id("mrst_word", 32'h0);
    chk("mrst_next", if_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
